param_mod_counter: RTL and testbench
====================================

// Module: param_mod_counter
// PURPOSE
//  Gen-2 start/stop modulo counter. Generalises the fixed 4-bit mod-14 counter to a
//  WIDTH-bit, MODULO-N up/down counter with synchronous load, a wrap pulse and a
//  STOP_DLY-deep stop pipeline. Used as a reusable event/timebase counter in sequentialLogic.
// PARAMETERS
//  WIDTH     4   count width; 2 <= MODULO <= 2**WIDTH
//  MODULO    14  count range 0..MODULO-1
//  STOP_DLY  2   stop delay-line depth, >= 1
// PORTS
//  clk       in   1      single clock, all logic on posedge
//  rst_n     in   1      synchronous, active-low reset
//  start     in   1      set count enable (level, sampled each edge)
//  stop      in   1      clear count enable
//  dir       in   1      1 = count up, 0 = count down
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  load value
//  count     out  WIDTH  current count
//  cnt_en    out  1      count-enable state
//  wrap      out  1      one-cycle pulse, count wrapped on last edge
//  stop_dly  out  1      stop delayed by STOP_DLY cycles
//  snapshot  out  WIDTH  count captured at stop (optional feature)
//  snap_vld  out  1      one-cycle snapshot-valid pulse (optional feature)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): count=0, cnt_en=0, wrap=0, stop_dly=0, all delay stages=0,
//    snapshot=0, snap_vld=0. Reset overrides every other input; mid-count reset aborts.
//  - cnt_en SR register: start -> 1; else stop -> 0; else hold. start beats stop if both high.
//  - Count uses registered cnt_en: start sampled at edge k -> first count change at edge k+1.
//  - Count priority per edge: load > (cnt_en & count) > hold.
//    * load: count <= (load_val >= MODULO) ? MODULO-1 : load_val; wrap=0; independent of cnt_en.
//    * up:   count==MODULO-1 -> 0 with wrap=1; else count+1.
//    * down: count==0 -> MODULO-1 with wrap=1; else count-1.
//    * dir may change any cycle; takes effect on the next enabled edge.
//  - wrap registered: high exactly in the cycle count shows the wrapped value; else 0.
//  - Count never leaves 0..MODULO-1. Arithmetic in WIDTH bits; MODULO=2**WIDTH wraps naturally.
//  - stop_dly: STOP_DLY-stage shift of raw stop, unaffected by start/cnt_en; latency STOP_DLY.
// CONFIGURATION
//  COUNTER_SNAPSHOT_EN defined: at an edge with stop=1, start=0, cnt_en=1, snapshot <= count
//    (pre-edge value) and snap_vld=1 for one cycle; snapshot holds until the next capture.
//    No capture when load is also high.
//  COUNTER_SNAPSHOT_EN undefined: no capture logic; snapshot tied 0, snap_vld tied 0.
//    Port list identical in both builds.
// TESTING
//  1 Defaults, rst_n low 2 cycles, start 1 cycle, dir=1 -> count 1..13,0; wrap high with 0;
//    cnt_en stays 1.
//  2 dir=0, load 1 cycle with load_val=3, enable -> 2,1,0,13 with wrap on 13; load_val=15
//    -> count=13.
//  3 start and stop high same edge -> cnt_en=1; stop alone -> cnt_en=0; count holds.
//  4 stop pulse 1 cycle -> stop_dly high exactly 2 cycles later for 1 cycle; STOP_DLY=4
//    -> 4 cycles.
//  5 rst_n low while count=7, cnt_en=1 -> next edge count=0, cnt_en=0, wrap=0.
//  6 SNAPSHOT_EN: count=9, stop -> snapshot=9, snap_vld 1 cycle; undefined -> both stay 0.

Source files
------------

// File: rtl/param_mod_counter.sv
// Purpose : WIDTH-bit modulo-MODULO up/down start/stop counter with load, wrap pulse and stop delay line.
// Latency : count/cnt_en/wrap update one edge after inputs are sampled; stop_dly lags stop by STOP_DLY edges.
// Backpres: none; every input is sampled on every clock edge.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, stop         set / clear of the count-enable register (start wins)
//   dir                 1 = up, 0 = down
//   load, load_val      synchronous load (clamped to MODULO-1), beats counting
//   count, cnt_en, wrap current count, enable state, registered wrap pulse
//   stop_dly            stop delayed by STOP_DLY cycles
//   snapshot, snap_vld  count captured at stop (only with COUNTER_SNAPSHOT_EN defined;
//                       otherwise both outputs are tied to 0)
module param_mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 14,
  parameter int STOP_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             wrap,
  output logic             stop_dly,
  output logic [WIDTH-1:0] snapshot,
  output logic             snap_vld
);

  // Highest legal count; for MODULO == 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

  logic [STOP_DLY-1:0] dly_q;
  logic                load_oor;

  // Zero-extend before comparing so an out-of-range load clamps correctly.
  assign load_oor = (32'(load_val) >= MODULO);
  assign stop_dly = dly_q[STOP_DLY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      cnt_en <= 1'b0;
      wrap   <= 1'b0;
      dly_q  <= '0;
    end else begin
      // Enable SR register: start has priority over stop.
      if (start)
        cnt_en <= 1'b1;
      else if (stop)
        cnt_en <= 1'b0;

      wrap <= 1'b0;
      if (load) begin
        count <= load_oor ? MAX_CNT : load_val;
      end else if (cnt_en) begin
        if (dir) begin
          if (count == MAX_CNT) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count <= MAX_CNT;
            wrap  <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end

      // Shift in raw stop; the cast drops the oldest stage and handles STOP_DLY == 1.
      dly_q <= STOP_DLY'({dly_q, stop});
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  // Capture the pre-edge count on the edge where an active counter is actually stopped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      if (stop && !start && cnt_en && !load) begin
        snapshot <= count;
        snap_vld <= 1'b1;
      end
    end
  end
`else
  assign snapshot = '0;
  assign snap_vld = 1'b0;
`endif

endmodule

// File: tb/tb_param_mod_counter.sv
// Purpose : directed self-checking bench for param_mod_counter (defaults plus a STOP_DLY=4 instance).
// Latency : inputs change #1 after a posedge; outputs are checked #1 after the next posedge.
// Backpres: not applicable.
module tb_param_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, dir, load;
  logic [3:0] load_val;
  logic [3:0] count, snapshot;
  logic       cnt_en, wrap, stop_dly, snap_vld;
  logic [3:0] count4, snapshot4;
  logic       cnt_en4, wrap4, stop_dly4, snap_vld4;

  int vectors = 0;
  int fails   = 0;

`ifdef COUNTER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  always #5 clk = ~clk;

  param_mod_counter #(.WIDTH(4), .MODULO(14), .STOP_DLY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .load(load), .load_val(load_val), .count(count), .cnt_en(cnt_en),
    .wrap(wrap), .stop_dly(stop_dly), .snapshot(snapshot), .snap_vld(snap_vld)
  );

  param_mod_counter #(.WIDTH(4), .MODULO(14), .STOP_DLY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .load(load), .load_val(load_val), .count(count4), .cnt_en(cnt_en4),
    .wrap(wrap4), .stop_dly(stop_dly4), .snapshot(snapshot4), .snap_vld(snap_vld4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1; load = 1'b0; load_val = 4'd0;

    // 1: reset state, then count up through the wrap
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_wrap", wrap, 0);
    check("rst_stop_dly", stop_dly, 0);
    check("rst_snapshot", snapshot, 0);
    check("rst_snap_vld", snap_vld, 0);

    rst_n = 1'b1; start = 1'b1;
    tick();
    check("start_en", cnt_en, 1);
    check("start_count", count, 0);
    start = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check("up_count", count, i);
      check("up_wrap", wrap, 0);
    end
    tick();
    check("up_wrap_count", count, 0);
    check("up_wrap_pulse", wrap, 1);
    check("up_en_held", cnt_en, 1);
    tick();
    check("up_after_wrap", count, 1);
    check("up_wrap_clear", wrap, 0);

    // 2: down count from a load, wrap to 13, clamped load
    dir = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    check("load3", count, 3);
    check("load_wrap", wrap, 0);
    load = 1'b0;
    tick(); check("dn2", count, 2);
    tick(); check("dn1", count, 1);
    tick(); check("dn0", count, 0); check("dn0_wrap", wrap, 0);
    tick(); check("dn13", count, 13); check("dn13_wrap", wrap, 1);
    tick(); check("dn12", count, 12); check("dn12_wrap", wrap, 0);
    load = 1'b1; load_val = 4'd15;
    tick();
    check("load_clamp", count, 13);
    load = 1'b0;

    // 3: start+stop together keeps enable; stop alone clears it
    start = 1'b1; stop = 1'b1;
    tick();
    check("both_en", cnt_en, 1);
    check("both_count", count, 12);
    start = 1'b0;
    tick();
    check("stop_en", cnt_en, 0);
    check("stop_count", count, 11);
    check("stop_snap_vld", snap_vld, SNAP);
    check("stop_snapshot", snapshot, SNAP ? 12 : 0);
    stop = 1'b0;
    tick();
    check("hold1", count, 11);
    check("snap_vld_drop", snap_vld, 0);
    tick();
    check("hold2", count, 11);
    tick(); tick();
    check("dly_idle", stop_dly, 0);
    check("dly4_idle", stop_dly4, 0);

    // 4: single stop pulse through the 2- and 4-deep delay lines
    stop = 1'b1;
    tick();
    check("dly_k0", stop_dly, 0);
    check("dly4_k0", stop_dly4, 0);
    check("nosnap_disabled", snap_vld, 0);
    stop = 1'b0;
    tick(); check("dly_k1", stop_dly, 1); check("dly4_k1", stop_dly4, 0);
    tick(); check("dly_k2", stop_dly, 0); check("dly4_k2", stop_dly4, 0);
    tick(); check("dly4_k3", stop_dly4, 1);
    tick(); check("dly4_k4", stop_dly4, 0);
    check("dly_count_hold", count, 11);

    // 5: reset mid-count
    dir = 1'b1; load = 1'b1; load_val = 4'd7; start = 1'b1;
    tick();
    check("pre_rst_count", count, 7);
    check("pre_rst_en", cnt_en, 1);
    load = 1'b0; start = 1'b0; rst_n = 1'b0;
    tick();
    check("midrst_count", count, 0);
    check("midrst_en", cnt_en, 0);
    check("midrst_wrap", wrap, 0);
    check("midrst_snapshot", snapshot, 0);
    rst_n = 1'b1;

    // 6: snapshot of 9 at stop
    load = 1'b1; load_val = 4'd9; start = 1'b1;
    tick();
    check("snap_pre_count", count, 9);
    load = 1'b0; start = 1'b0; stop = 1'b1;
    tick();
    check("snap_count", count, 10);
    check("snap_en", cnt_en, 0);
    check("snap_vld", snap_vld, SNAP);
    check("snap_val", snapshot, SNAP ? 9 : 0);
    stop = 1'b0;
    tick();
    check("snap_vld_pulse", snap_vld, 0);
    check("snap_hold", snapshot, SNAP ? 9 : 0);
    check("snap_count_hold", count, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
